// File: rtl/fixed_point_signed_divider_iter.sv
// Iterative signed fixed-point divider: restoring long division on magnitudes,
// one quotient bit per clock, with valid/ready handshakes, saturation and divide-by-zero flagging.
module fixed_point_signed_divider_iter #(
  parameter int WIDTH = 8,
  parameter int FRAC  = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_quotient,
  output logic             o_dbz,
  output logic             o_ovf
);

  localparam int N  = WIDTH + FRAC;
  localparam int CW = $clog2(N + 1);

  localparam logic [N-1:0]     RAW_HALF = {{(N-1){1'b0}}, 1'b1} << (WIDTH - 1);
  localparam logic [N-1:0]     RAW_MAX  = RAW_HALF - N'(1);
  localparam logic [WIDTH-1:0] Q_MAX    = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] Q_MIN    = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             ready_q, valid_q, dbz_out_q, ovf_q;
  logic [WIDTH-1:0] quot_q;

  logic [N-1:0]     num_q, quo_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic             neg_q, dvd_neg_q, dbz_q;

  logic [WIDTH-1:0] dvd_mag_d, dvs_mag_d, quot_d;
  logic [WIDTH:0]   rem_shift_d, rem_d;
  logic             q_bit_d, ovf_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    dvd_mag_d   = i_dividend[WIDTH-1] ? (~i_dividend + WIDTH'(1)) : i_dividend;
    dvs_mag_d   = i_divisor[WIDTH-1]  ? (~i_divisor  + WIDTH'(1)) : i_divisor;

    rem_shift_d = {rem_q[WIDTH-1:0], num_q[N-1]};
    q_bit_d     = (rem_shift_d >= {1'b0, dvs_q});
    rem_d       = q_bit_d ? (rem_shift_d - {1'b0, dvs_q}) : rem_shift_d;

    quot_d = quo_q[WIDTH-1:0];
    ovf_d  = 1'b0;
    if (dbz_q) begin
      quot_d = dvd_neg_q ? Q_MIN : Q_MAX;
    end else if (!neg_q) begin
      if (quo_q > RAW_MAX) begin
        quot_d = Q_MAX;
        ovf_d  = 1'b1;
      end
    end else if (quo_q > RAW_HALF) begin
      quot_d = Q_MIN;
      ovf_d  = 1'b1;
    end else begin
      // Negating a raw of exactly 2^(WIDTH-1) wraps to MIN, and zero stays zero.
      quot_d = ~quo_q[WIDTH-1:0] + WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      quot_q    <= '0;
      dbz_out_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (i_valid && ready_q) begin
          state_q <= S_BUSY;
          ready_q <= 1'b0;
          cnt_q   <= CW'(N);
        end
        S_BUSY: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= S_FIX;
        end
        S_FIX: begin
          quot_q    <= quot_d;
          dbz_out_q <= dbz_q;
          ovf_q     <= ovf_d;
          valid_q   <= 1'b1;
          state_q   <= S_DONE;
        end
        S_DONE: if (i_ready) begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // NOTE: the datapath is left unreset; every register is loaded at acceptance before it is used.
  always_ff @(posedge i_clk) begin
    if (state_q == S_IDLE && i_valid) begin
      num_q     <= N'(dvd_mag_d) << FRAC;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= dvs_mag_d;
      neg_q     <= i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
      dvd_neg_q <= i_dividend[WIDTH-1];
      dbz_q     <= (i_divisor == '0);
    end else if (state_q == S_BUSY) begin
      num_q <= num_q << 1;
      rem_q <= rem_d;
      quo_q <= {quo_q[N-2:0], q_bit_d};
    end
  end

  assign o_ready    = ready_q;
  assign o_valid    = valid_q;
  assign o_quotient = quot_q;
  assign o_dbz      = dbz_out_q;
  assign o_ovf      = ovf_q;

endmodule

// File: tb/tb_fixed_point_signed_divider_iter.sv
// Scoreboard bench: directed vectors on an 8.4 divider and a random sweep on a 16.8 divider
// checked against an integer-arithmetic reference model.
module tb_fixed_point_signed_divider_iter;

  typedef struct {
    logic [31:0] q;
    bit          dbz;
    bit          ovf;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic i_reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 8-bit, FRAC=4 instance
  logic       v8_in = 1'b0, r8_in = 1'b1;
  logic [7:0] dvd8 = '0, dvs8 = '0;
  logic       rdy8, val8, dbz8, ovf8;
  logic [7:0] q8_out;

  fixed_point_signed_divider_iter #(.WIDTH(8), .FRAC(4)) dut8 (
    .i_clk(clk), .i_reset(i_reset), .i_valid(v8_in), .o_ready(rdy8),
    .i_dividend(dvd8), .i_divisor(dvs8), .o_valid(val8), .i_ready(r8_in),
    .o_quotient(q8_out), .o_dbz(dbz8), .o_ovf(ovf8)
  );

  // 16-bit, FRAC=8 instance
  logic        v16_in = 1'b0, r16_in = 1'b1;
  logic [15:0] dvd16 = '0, dvs16 = '0;
  logic        rdy16, val16, dbz16, ovf16;
  logic [15:0] q16_out;

  fixed_point_signed_divider_iter #(.WIDTH(16), .FRAC(8)) dut16 (
    .i_clk(clk), .i_reset(i_reset), .i_valid(v16_in), .o_ready(rdy16),
    .i_dividend(dvd16), .i_divisor(dvs16), .o_valid(val16), .i_ready(r16_in),
    .o_quotient(q16_out), .o_dbz(dbz16), .o_ovf(ovf16)
  );

  exp_t sb8[$];
  exp_t sb16[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Reference: q = trunc((a * 2^f) / b), clamped to the signed w-bit range.
  function automatic void model(input int w, input int f, input logic [31:0] a_raw,
                                input logic [31:0] b_raw, output logic [31:0] q,
                                output bit dbz, output bit ovf);
    longint a, b, mx, mn, r;
    longint full;
    full = longint'(1) << w;
    a  = longint'(a_raw) & (full - 1);
    b  = longint'(b_raw) & (full - 1);
    if (a >= full / 2) a -= full;
    if (b >= full / 2) b -= full;
    mx = full / 2 - 1;
    mn = -(full / 2);
    dbz = 1'b0;
    ovf = 1'b0;
    if (b == 0) begin
      dbz = 1'b1;
      r   = (a >= 0) ? mx : mn;
    end else begin
      r = (a * (longint'(1) << f)) / b;
      if (r > mx) begin r = mx; ovf = 1'b1; end
      else if (r < mn) begin r = mn; ovf = 1'b1; end
    end
    q = 32'(r & (full - 1));
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send8(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input bit edbz, input bit eovf);
    exp_t e;
    bit   ok = 1'b0;
    dvd8 = a; dvs8 = b; v8_in = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (rdy8) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      timeout("send8_ready");
      v8_in = 1'b0;
      return;
    end
    e.q = {24'b0, eq}; e.dbz = edbz; e.ovf = eovf; e.acc = cyc + 1;
    sb8.push_back(e);
    @(posedge clk); #1;
    v8_in = 1'b0;
    dvd8 = 8'($urandom);
    dvs8 = 8'($urandom);
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    bit   ok = 1'b0;
    dvd16 = a; dvs16 = b; v16_in = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (rdy16) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      timeout("send16_ready");
      v16_in = 1'b0;
      return;
    end
    model(16, 8, {16'b0, a}, {16'b0, b}, e.q, e.dbz, e.ovf);
    e.acc = cyc + 1;
    sb16.push_back(e);
    @(posedge clk); #1;
    v16_in = 1'b0;
    dvd16 = 16'($urandom);
    dvs16 = 16'($urandom);
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while ((sb8.size() != 0 || sb16.size() != 0) && t < budget) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (sb8.size() != 0 || sb16.size() != 0) begin
      timeout("drain");
      sb8.delete();
      sb16.delete();
    end
  endtask

  // Monitors: compare on every falling edge while o_valid is high, pop on handshake.
  bit prev_v8 = 1'b0, prev_v16 = 1'b0;

  always @(negedge clk) begin
    if (val8) begin
      if (sb8.size() == 0) begin
        timeout("unexpected_valid8");
      end else begin
        if (!prev_v8) check("latency8", 32'(cyc - sb8[0].acc), 32'd13);
        check("quot8", {24'b0, q8_out}, sb8[0].q);
        check("dbz8", {31'b0, dbz8}, {31'b0, sb8[0].dbz});
        check("ovf8", {31'b0, ovf8}, {31'b0, sb8[0].ovf});
        check("ready_in_done8", {31'b0, rdy8}, 32'd0);
        if (r8_in) void'(sb8.pop_front());
      end
    end
    prev_v8 = val8;
  end

  always @(negedge clk) begin
    if (val16) begin
      if (sb16.size() == 0) begin
        timeout("unexpected_valid16");
      end else begin
        if (!prev_v16) check("latency16", 32'(cyc - sb16[0].acc), 32'd25);
        check("quot16", {16'b0, q16_out}, sb16[0].q);
        check("dbz16", {31'b0, dbz16}, {31'b0, sb16[0].dbz});
        check("ovf16", {31'b0, ovf16}, {31'b0, sb16[0].ovf});
        if (r16_in) void'(sb16.pop_front());
      end
    end
    prev_v16 = val16;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;
    check("rst_ready", {31'b0, rdy8}, 32'd1);
    check("rst_valid", {31'b0, val8}, 32'd0);
    check("rst_quot", {24'b0, q8_out}, 32'd0);
    check("rst_flags", {30'b0, dbz8, ovf8}, 32'd0);

    // Basic, truncation, no negative zero, saturation and divide-by-zero.
    send8(8'h18, 8'h08, 8'h30, 1'b0, 1'b0);
    send8(8'hE0, 8'h0C, 8'hD6, 1'b0, 1'b0);
    send8(8'h01, 8'h70, 8'h00, 1'b0, 1'b0);
    send8(8'h70, 8'h04, 8'h7F, 1'b0, 1'b1);
    send8(8'h80, 8'hF0, 8'h7F, 1'b0, 1'b1);
    send8(8'h80, 8'h10, 8'h80, 1'b0, 1'b0);
    send8(8'h10, 8'h00, 8'h7F, 1'b1, 1'b0);
    send8(8'hF0, 8'h00, 8'h80, 1'b1, 1'b0);
    send8(8'h00, 8'h00, 8'h7F, 1'b1, 1'b0);
    send8(8'h00, 8'hF0, 8'h00, 1'b0, 1'b0);
    drain(500);

    // Backpressure: the monitor re-checks the held result on every cycle.
    r8_in = 1'b0;
    send8(8'hE8, 8'h20, 8'hF4, 1'b0, 1'b0);
    begin
      int t = 0;
      while (!val8 && t < 100) begin @(posedge clk); t++; end
      if (!val8) timeout("bp_valid");
    end
    repeat (20) @(posedge clk);
    #1 r8_in = 1'b1;
    drain(100);

    // Reset mid-BUSY discards the operation; a fresh one then completes.
    send8(8'h20, 8'h08, 8'h40, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1 i_reset = 1'b1;
    @(posedge clk);
    #1 i_reset = 1'b0;
    sb8.delete();
    check("midrst_ready", {31'b0, rdy8}, 32'd1);
    check("midrst_valid", {31'b0, val8}, 32'd0);
    check("midrst_quot", {24'b0, q8_out}, 32'd0);
    check("midrst_flags", {30'b0, dbz8, ovf8}, 32'd0);
    send8(8'hE0, 8'h0C, 8'hD6, 1'b0, 1'b0);
    drain(100);

    // Random sweep on the 16.8 divider with occasional corner operands.
    for (int i = 0; i < 200; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      case ($urandom_range(0, 7))
        0: b = 16'h0000;
        1: b = 16'($urandom_range(0, 15)) - 16'd8;
        2: a = 16'h8000;
        3: b = {{8{b[15]}}, b[7:0]};
        default: ;
      endcase
      send16(a, b);
    end
    drain(500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fixed_point_signed_divider_iter.md
Name: fixed_point_signed_divider_iter

Overview:
- Parametrised successor to the team's 8-bit signed fixed-point long divider.
- Computes a signed Qm.f quotient one bit per clock using restoring long division on magnitudes.
- Adds a valid/ready handshake on input and output, output backpressure, divide-by-zero and overflow flags, and saturation.
- Sits in the fixed-point DSP datapath wherever gain normalisation or ratio computation is needed.

Parameters:
WIDTH, 8, total bits of dividend, divisor and quotient (two's complement); legal range 2..32.
FRAC, 4, fractional bits shared by all operands and the result; 0 <= FRAC < WIDTH.

Ports:
i_clk  input  1  clock; all logic is rising-edge.
i_reset  input  1  synchronous, active-high reset.
i_valid  input  1  operand pair valid.
o_ready  output  1  divider can accept operands (high only in IDLE).
i_dividend  input  WIDTH  signed dividend.
i_divisor  input  WIDTH  signed divisor.
o_valid  output  1  result valid; held until accepted.
i_ready  input  1  downstream accepts the result.
o_quotient  output  WIDTH  signed quotient, saturated.
o_dbz  output  1  divide-by-zero flag, qualified by o_valid.
o_ovf  output  1  overflow/saturation flag, qualified by o_valid.

Behaviour:
- Reset (i_reset high at a rising edge): state=IDLE; o_ready=1, o_valid=0, o_quotient=0, o_dbz=0, o_ovf=0. Applies in any state; an in-flight operation is discarded.
- Math: q = trunc_toward_zero((dividend * 2^FRAC) / divisor).
  - N = WIDTH+FRAC iterations.
  - Internal magnitudes: |dividend| is WIDTH bits unsigned. Numerator = |dividend| << FRAC, N bits. Partial remainder is WIDTH+1 bits. Raw quotient is N bits unsigned.
  - Result sign = sign(dividend) XOR sign(divisor).
- States:
  - IDLE: o_ready=1. On i_valid&&o_ready, capture magnitudes, signs and a zero-divisor flag; load the counter with N; go to BUSY.
  - BUSY: each cycle, shift one numerator bit into the remainder, trial-subtract |divisor|, set one quotient bit, decrement the counter. After N cycles go to FIX.
  - FIX (1 cycle): apply sign and saturation, register o_quotient/o_dbz/o_ovf, go to DONE.
  - DONE: o_valid=1. Outputs are stable while i_ready=0. On i_ready=1, go to IDLE next cycle.
- No new operands are accepted in DONE; back-to-back throughput is one result per N+3 cycles with i_ready tied high.
- Latency: with acceptance at edge k, o_valid is high after edge k+N+1; for WIDTH=8, FRAC=4 that is edge k+13. Latency is fixed for all operands, including divide-by-zero.
- Saturation (MAX=2^(WIDTH-1)-1, MIN=-2^(WIDTH-1)):
  - Positive result with raw > MAX gives MAX and o_ovf=1.
  - Negative result with raw > 2^(WIDTH-1) gives MIN and o_ovf=1.
  - Negative result with raw == 2^(WIDTH-1) gives exactly MIN with o_ovf=0.
  - A zero raw quotient is output as 0, never negative zero.
- Divide-by-zero: i_divisor==0 sets o_dbz=1 and o_ovf=0. Result is MAX if dividend >= 0, MIN if dividend < 0. Iterations still run, but their result is ignored.
- Operand inputs are sampled only at acceptance; changes on them during BUSY or DONE have no effect.
- i_valid while o_ready=0 is ignored; the source must hold it.
- o_dbz and o_ovf are don't-care when o_valid=0 but are held at their last values.

Test Plan:
1. WIDTH=8, FRAC=4: 0x18 (1.5) / 0x08 (0.5) -> o_quotient=0x30, dbz=0, ovf=0; o_valid rises exactly 13 edges after acceptance.
2. 0xE0 (-2.0) / 0x0C (0.75) -> 0xD6 (-2.625, truncated toward zero); then 0x01 / 0x70 -> 0x00 (no negative zero).
3. Overflow: 0x70 / 0x04 -> 0x7F with ovf=1. 0x80 / 0xF0 (-8/-1) -> 0x7F with ovf=1. 0x80 / 0x10 (-8/1) -> 0x80 with ovf=0.
4. Divide-by-zero: 0x10/0x00 -> 0x7F, dbz=1. 0xF0/0x00 -> 0x80, dbz=1. 0x00/0x00 -> 0x7F, dbz=1. Latency is identical to case 1.
5. Backpressure: hold i_ready=0 for 20 cycles in DONE -> o_valid and outputs stay constant and o_ready stays 0. Toggle i_dividend during BUSY -> no effect on the result.
6. Assert i_reset mid-BUSY -> next cycle o_ready=1, o_valid=0, outputs 0; a new operation then completes correctly.
- Also run a random sweep versus a reference model for WIDTH=16, FRAC=8.
